// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates I-cache and D-cache line requests onto one physical-memory port.
// Optional ARB_RR_EN: round-robin tie-break instead of fixed D priority.
module mem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int LINE_W = 128
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_read,
    input  logic              i_write,
    input  logic [ADDR_W-1:0] i_address,
    input  logic [LINE_W-1:0] i_wdata,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);
    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;
    state_t state, state_nx;
    logic i_req, d_req, gnt_i, gnt_d;
    assign i_req = i_read | i_write;
    assign d_req = d_read | d_write;
`ifdef ARB_RR_EN
    // last_d = 1 when D won the most recent grant; on a tie the other side wins
    logic last_d;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) last_d <= 1'b0;
        else if (state == IDLE && (gnt_i | gnt_d)) last_d <= gnt_d;
    assign gnt_d = d_req & (~i_req | ~last_d);
`else
    assign gnt_d = d_req;
`endif
    assign gnt_i = i_req & ~gnt_d;
    always_comb begin
        state_nx = state;
        if (state == IDLE) state_nx = gnt_d ? SERVE_D : (gnt_i ? SERVE_I : IDLE);
        else if (pmem_resp) state_nx = IDLE;
    end
    // Command is latched at grant so a requester dropping its strobes cannot abort it
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
            pmem_address <= '0;
            pmem_wdata   <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE) begin
                pmem_write   <= gnt_d ? d_write : (gnt_i & i_write);
                pmem_read    <= gnt_d ? (d_read & ~d_write) : (gnt_i & i_read & ~i_write);
                pmem_address <= gnt_d ? d_address : (gnt_i ? i_address : '0);
                pmem_wdata   <= gnt_d ? d_wdata : (gnt_i ? i_wdata : '0);
            end else if (pmem_resp) begin
                pmem_read    <= 1'b0;
                pmem_write   <= 1'b0;
                pmem_address <= '0;
                pmem_wdata   <= '0;
            end
        end
    end
    assign i_resp  = pmem_resp && (state == SERVE_I);
    assign d_resp  = pmem_resp && (state == SERVE_D);
    assign i_rdata = pmem_rdata;
    assign d_rdata = pmem_rdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table-driven transactions with a command scoreboard plus reset/idle-response sequences.
module tb_mem_arbiter;
`ifdef ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         i_read = 1'b0, i_write = 1'b0, d_read = 1'b0, d_write = 1'b0;
    logic [15:0]  i_address = '0, d_address = '0;
    logic [127:0] i_wdata = '0, d_wdata = '0, pmem_rdata = '0;
    logic         pmem_resp = 1'b0;
    logic [127:0] i_rdata, d_rdata, pmem_wdata;
    logic         i_resp, d_resp, pmem_read, pmem_write;
    logic [15:0]  pmem_address;

    mem_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .i_read(i_read), .i_write(i_write), .i_address(i_address), .i_wdata(i_wdata),
        .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit ir, iw; logic [15:0] ia;
        bit dr, dw; logic [15:0] da;
        int lat; bit hold, drop, pre_rst;
        bit gd, erd, ewr; logic [15:0] eaddr;
    } row_t;
    typedef struct {
        bit gd, rd, wr; logic [15:0] addr; logic [127:0] wdata;
    } exp_t;

    row_t tbl [11];
    exp_t sbq [$];
    int errors = 0, checks = 0;

    task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask

    function automatic row_t mk(bit ir, bit iw, logic [15:0] ia, bit dr, bit dw, logic [15:0] da,
                                int lat, bit hold, bit drop, bit pre_rst,
                                bit gd, bit erd, bit ewr, logic [15:0] eaddr);
        row_t r;
        r.ir = ir; r.iw = iw; r.ia = ia; r.dr = dr; r.dw = dw; r.da = da;
        r.lat = lat; r.hold = hold; r.drop = drop; r.pre_rst = pre_rst;
        r.gd = gd; r.erd = erd; r.ewr = ewr; r.eaddr = eaddr;
        return r;
    endfunction

    task automatic check_quiet(input string tag);
        chk({tag, "_rd"}, pmem_read, 0);
        chk({tag, "_wr"}, pmem_write, 0);
        chk({tag, "_iresp"}, i_resp, 0);
        chk({tag, "_dresp"}, d_resp, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_quiet("rst");
        chk("rst_addr", pmem_address, 0);
        chk("rst_wdata", pmem_wdata, 0);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Called at a negedge inside an IDLE cycle; returns at the negedge of the following IDLE cycle.
    task automatic run_row(input row_t r);
        exp_t e;
        logic [127:0] rd;
        int n;
        if (r.pre_rst) do_reset();
        i_wdata = {$urandom, $urandom, $urandom, $urandom};
        d_wdata = {$urandom, $urandom, $urandom, $urandom};
        i_read = r.ir; i_write = r.iw; i_address = r.ia;
        d_read = r.dr; d_write = r.dw; d_address = r.da;
        e.gd = r.gd; e.rd = r.erd; e.wr = r.ewr; e.addr = r.eaddr;
        e.wdata = r.gd ? d_wdata : i_wdata;
        sbq.push_back(e);
        n = 0;
        @(negedge clk);
        while (!(pmem_read || pmem_write) && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_latency", n, 0);
        e = sbq.pop_front();
        chk("cmd_read", pmem_read, e.rd);
        chk("cmd_write", pmem_write, e.wr);
        chk("cmd_addr", pmem_address, e.addr);
        chk("cmd_wdata", pmem_wdata, e.wdata);
        chk("pre_iresp", i_resp, 0);
        chk("pre_dresp", d_resp, 0);
        if (r.drop) begin
            if (e.gd) begin d_read = 1'b0; d_write = 1'b0; end
            else begin i_read = 1'b0; i_write = 1'b0; end
        end
        for (int k = 1; k < r.lat; k++) begin
            @(negedge clk);
            chk("held_read", pmem_read, e.rd);
            chk("held_write", pmem_write, e.wr);
            chk("held_addr", pmem_address, e.addr);
            chk("wait_iresp", i_resp, 0);
            chk("wait_dresp", d_resp, 0);
        end
        rd = {$urandom, $urandom, $urandom, $urandom};
        pmem_rdata = rd;
        pmem_resp = 1'b1;
        #1;
        chk("i_resp", i_resp, !e.gd);
        chk("d_resp", d_resp, e.gd);
        chk("i_rdata", i_rdata, rd);
        chk("d_rdata", d_rdata, rd);
        @(posedge clk);
        #1;
        pmem_resp = 1'b0;
        if (!r.hold) begin
            if (e.gd) begin d_read = 1'b0; d_write = 1'b0; end
            else begin i_read = 1'b0; i_write = 1'b0; end
        end
        @(negedge clk);
        check_quiet("idle_gap");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        //              ir iw ia       dr dw da       lat hold drop rst gd   erd ewr eaddr
        tbl[0]  = mk(1, 0, 16'h1000, 0, 0, 16'h0000, 3, 0, 0, 0, 1'b0, 1, 0, 16'h1000);
        tbl[1]  = mk(1, 0, 16'h1100, 0, 1, 16'h2000, 2, 0, 0, 0, 1'b1, 0, 1, 16'h2000);
        tbl[2]  = mk(1, 0, 16'h1100, 0, 0, 16'h0000, 1, 0, 0, 0, 1'b0, 1, 0, 16'h1100);
        tbl[3]  = mk(1, 1, 16'h00F0, 0, 0, 16'h0000, 1, 0, 0, 0, 1'b0, 0, 1, 16'h00F0);
        tbl[4]  = mk(0, 0, 16'h0000, 1, 0, 16'h3000, 3, 0, 1, 0, 1'b1, 1, 0, 16'h3000);
        tbl[5]  = mk(0, 0, 16'h0000, 1, 1, 16'h3010, 1, 0, 0, 0, 1'b1, 0, 1, 16'h3010);
        tbl[6]  = mk(1, 0, 16'h6000, 0, 0, 16'h0000, 2, 0, 0, 0, 1'b0, 1, 0, 16'h6000);
        tbl[7]  = mk(1, 0, 16'h4000, 1, 0, 16'h5000, 1, 1, 0, 1, 1'b1, 1, 0, 16'h5000);
        tbl[8]  = mk(1, 0, 16'h4000, 1, 0, 16'h5000, 1, 1, 0, 0, !RR,  1, 0, RR ? 16'h4000 : 16'h5000);
        tbl[9]  = mk(1, 0, 16'h4000, 1, 0, 16'h5000, 1, 1, 0, 0, 1'b1, 1, 0, 16'h5000);
        tbl[10] = mk(1, 0, 16'h4000, 1, 0, 16'h5000, 1, 1, 0, 0, !RR,  1, 0, RR ? 16'h4000 : 16'h5000);

        repeat (2) @(negedge clk);
        check_quiet("por");
        chk("por_addr", pmem_address, 0);
        reset_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            if (i == 6) begin
                // reset while serving I: command drops at once and the lost transaction never responds
                i_read = 1'b1; i_address = 16'h6000;
                @(negedge clk);
                chk("rs_cmd", pmem_read, 1);
                #2;
                reset_n = 1'b0;
                pmem_resp = 1'b1;
                #1;
                chk("rs_read", pmem_read, 0);
                chk("rs_addr", pmem_address, 0);
                chk("rs_iresp", i_resp, 0);
                @(negedge clk);
                reset_n = 1'b1;
                i_read = 1'b0;
                #1;
                chk("rs_post_iresp", i_resp, 0);
                @(negedge clk);
                check_quiet("rs_post");
                pmem_resp = 1'b0;
                // memory response arriving in IDLE is ignored
                @(negedge clk);
                pmem_resp = 1'b1;
                #1;
                chk("idle_iresp", i_resp, 0);
                chk("idle_dresp", d_resp, 0);
                @(negedge clk);
                pmem_resp = 1'b0;
                check_quiet("idle_after");
            end
            run_row(tbl[i]);
        end
        i_read = 1'b0; d_read = 1'b0;
        repeat (2) @(negedge clk);
        check_quiet("final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
